// File: rtl/fp_wb_completion_arbiter_if.sv
// Producer-side and writeback-side signals of the FP completion arbiter.
// The arbiter takes the master modport; FP units and the regfile take slave. Optional FP_WB_FFLAGS_EN adds flag signals.
interface fp_wb_completion_arbiter_if #(
    parameter int NUM_UNITS = 3,
    parameter int XLEN      = 32
);
    logic [NUM_UNITS-1:0]           in_valid;
    logic [NUM_UNITS-1:0][4:0]      in_rd;
    logic [NUM_UNITS-1:0][XLEN-1:0] in_data;
    logic [NUM_UNITS-1:0]           in_ready;
    logic                           wb_ready;
    logic                           wb_valid;
    logic [4:0]                     waddr_wb;
    logic [XLEN-1:0]                wb_data;
    logic                           fp_reg_write_wb;
`ifdef FP_WB_FFLAGS_EN
    logic [NUM_UNITS-1:0][4:0]      in_fflags;
    logic [4:0]                     wb_fflags;
    logic [4:0]                     fflags_accum;
    logic                           fflags_clr;
`endif

    modport master (
        input  in_valid, in_rd, in_data, wb_ready,
`ifdef FP_WB_FFLAGS_EN
        input  in_fflags, fflags_clr,
        output wb_fflags, fflags_accum,
`endif
        output in_ready, wb_valid, waddr_wb, wb_data, fp_reg_write_wb
    );

    modport slave (
        output in_valid, in_rd, in_data, wb_ready,
`ifdef FP_WB_FFLAGS_EN
        output in_fflags, fflags_clr,
        input  wb_fflags, fflags_accum,
`endif
        input  in_ready, wb_valid, waddr_wb, wb_data, fp_reg_write_wb
    );
endinterface

// File: rtl/fp_wb_completion_arbiter.sv
// Round-robin collection of FP unit results into an in-order FIFO feeding the single FP writeback port.
// Optional FP_WB_FFLAGS_EN stores per-entry exception flags and keeps a sticky accumulator.
module fp_wb_completion_arbiter #(
    parameter int NUM_UNITS = 3,
    parameter int DEPTH     = 4,
    parameter int XLEN      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    fp_wb_completion_arbiter_if.master bus,
    output logic [31:0]               pending_rd_mask,
    output logic [$clog2(DEPTH):0]    fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int UW = $clog2(NUM_UNITS);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [4:0]      ent_rd   [DEPTH];
    logic [XLEN-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0] ent_valid, valid_next;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count;
    logic [UW-1:0]   rr_ptr, gidx;
    logic [NUM_UNITS-1:0] grant;
    logic            found, push, pop;
    logic [4:0]      push_rd;
    logic [31:0]     mask_next;

    // Ready depends only on registered count, so a same-cycle pop never frees a slot.
    always_comb begin
        int unsigned idx;
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        if (!reset && count != FULL) begin
            for (int unsigned k = 0; k < NUM_UNITS; k++) begin
                idx = 32'(rr_ptr) + k;
                if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
                if (!found && bus.in_valid[UW'(idx)]) begin
                    grant[UW'(idx)] = 1'b1;
                    gidx  = UW'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    assign push         = found;
    assign push_rd      = bus.in_rd[gidx];
    assign bus.in_ready = grant;

    assign bus.wb_valid        = ent_valid[rd_ptr] & ~reset;
    assign bus.waddr_wb        = ent_rd[rd_ptr];
    assign bus.wb_data         = ent_data[rd_ptr];
    assign pop                 = bus.wb_valid & bus.wb_ready;
    assign bus.fp_reg_write_wb = pop;

    always_comb begin
        logic       v;
        logic [4:0] r;
        valid_next = '0;
        mask_next  = '0;
        v = 1'b0;
        r = '0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            v = ent_valid[e];
            r = ent_rd[e];
            if (pop && PW'(e) == rd_ptr) v = 1'b0;
            if (push && PW'(e) == wr_ptr) begin
                v = 1'b1;
                r = push_rd;
            end
            valid_next[e] = v;
            if (v) mask_next[r] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            rr_ptr          <= '0;
            ent_valid       <= '0;
            pending_rd_mask <= '0;
        end else begin
            ent_valid       <= valid_next;
            pending_rd_mask <= mask_next;
            if (push) begin
                ent_rd[wr_ptr]   <= push_rd;
                ent_data[wr_ptr] <= bus.in_data[gidx];
                wr_ptr           <= wr_ptr + 1'b1;
                rr_ptr           <= (gidx == UW'(NUM_UNITS - 1)) ? '0 : gidx + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign fifo_count = count;

`ifdef FP_WB_FFLAGS_EN
    logic [4:0] ent_fflags [DEPTH];
    logic [4:0] accum;

    assign bus.wb_fflags    = ent_fflags[rd_ptr];
    assign bus.fflags_accum = accum;

    // A clear coinciding with a pop keeps the popped flags rather than zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            accum <= '0;
        end else begin
            if (push) ent_fflags[wr_ptr] <= bus.in_fflags[gidx];
            if (bus.fflags_clr) accum <= pop ? bus.wb_fflags : 5'd0;
            else if (pop)       accum <= accum | bus.wb_fflags;
        end
    end
`endif
endmodule

// File: doc/fp_wb_completion_arbiter.md
Name: fp_wb_completion_arbiter

Overview:
- Writeback-side counterpart of the FP busy-register scoreboard. It collects completed results from NUM_UNITS multi-cycle FP functional units (add/mul, div/sqrt, FMA), buffers them in an in-order completion FIFO, and drains one result per accepted cycle onto the single FP register-file write port.
- Each accepted writeback is exactly the event that clears the scoreboard busy bit for its rd. The block therefore produces the clear strobe and address (fp_reg_write_wb, waddr_wb).

Parameters:
- NUM_UNITS, 3: number of FP producer ports (2..8).
- DEPTH, 4: completion FIFO entries (power of two, at least 2).
- XLEN, 32: result data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  [NUM_UNITS-1:0]  unit i has a completed result.
- in_rd  in  [NUM_UNITS-1:0][4:0]  destination FP register per unit.
- in_data  in  [NUM_UNITS-1:0][XLEN-1:0]  result per unit.
- in_ready  out  [NUM_UNITS-1:0]  one-hot grant; unit i's result is taken this cycle.
- wb_ready  in  1  FP regfile write port is free this cycle.
- wb_valid  out  1  FIFO head is valid.
- waddr_wb  out  5  rd of FIFO head.
- wb_data  out  XLEN  data of FIFO head.
- fp_reg_write_wb  out  1  wb_valid & wb_ready; the scoreboard clear strobe.
- pending_rd_mask  out  32  bit r set while any FIFO entry targets fr.
- fifo_count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset, synchronous while reset=1:
  - wr_ptr, rd_ptr and count go to 0; round-robin pointer goes to 0.
  - All entry-valid bits clear.
  - Outputs: wb_valid=0, fp_reg_write_wb=0, in_ready=0, pending_rd_mask=0, fifo_count=0. waddr_wb and wb_data are don't-care but must not cause X on wb_valid.
  - Any results presented during reset are dropped and not acknowledged.
- Arbitration, combinational:
  - When count<DEPTH, grant exactly one requesting unit. The winner is the first requester at or after rr_ptr, wrapping modulo NUM_UNITS.
  - in_ready is the one-hot grant. A unit must hold in_valid/in_rd/in_data stable until it is granted.
  - When count==DEPTH (full), in_ready=0 for all units. A pop in the same cycle does not open a push slot; ready depends only on registered count.
- rr_ptr update: on a grant to unit g, rr_ptr <= (g+1) mod NUM_UNITS. With no grant, rr_ptr holds.
- Push: a grant writes {rd, data} at wr_ptr and increments wr_ptr, wrapping at DEPTH. The entry is visible at the head no earlier than the next cycle, so latency from in_valid&in_ready to wb_valid is 1 cycle minimum.
- Pop:
  - When wb_valid & wb_ready, rd_ptr increments with wrap and fp_reg_write_wb=1 in the same cycle.
  - waddr_wb/wb_data are the head entry, driven from registers/array with no combinational path from in_*.
- Simultaneous push and pop: count is unchanged and both pointers advance. Empty with a push and no pop gives count=1 next cycle.
- Ordering: results retire strictly in acceptance order. Two entries with the same rd retire in order (WAW safe).
- pending_rd_mask:
  - OR over valid entries of the one-hot decode of the entry's rd.
  - Updated with the FIFO state and registered, so it reflects entries after the edge.
  - The entry popped this cycle is excluded from the next cycle's mask unless another entry holds the same rd.
- fifo_count always equals the number of valid entries, in 0..DEPTH.

Optional Feature:
- Macro: FP_WB_FFLAGS_EN.
- Defined:
  - Adds port in_fflags [NUM_UNITS-1:0][4:0], stored per entry.
  - Adds output wb_fflags [4:0] (head flags).
  - Adds output fflags_accum [4:0], a sticky OR of wb_fflags on every fp_reg_write_wb. It is cleared by reset or by input fflags_clr (1 bit). If the clear coincides with a pop, the result is the popped entry's flags.
- Undefined: these ports and storage are absent; behaviour is otherwise identical.

Test Plan:
- Single result: unit 1 presents rd=5, data=0x3F800000 with wb_ready=1 → in_ready=3'b010 at cycle 0; at cycle 1 wb_valid=1, waddr_wb=5, fp_reg_write_wb=1; mask bit 5 set at cycle 1 only.
- Round-robin: all 3 units request continuously with wb_ready=0 → grants go to units 0,1,2,0 over 4 cycles; then full gives in_ready=0 and fifo_count=4.
- Drain ordering: from the full state, set wb_ready=1 → waddr_wb follows acceptance order over 4 cycles, fifo_count goes 4→0, then wb_valid=0.
- Same rd (WAW): unit 0 rd=7 then unit 2 rd=7 → two pops of rd 7 in order; pending_rd_mask[7] stays 1 until the second pop.
- Push/pop in same cycle at count=2 → count stays 2, both pointers advance; pointer wrap past DEPTH-1 is checked.
- Reset mid-stream: assert reset with count=3 → next cycle wb_valid=0, mask=0, count=0, rr_ptr=0; the first grant after reset goes to the lowest-index requester.
